// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-access sequencer.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, RESP} reg_acc_state_t;

  localparam logic RW_READ = 1'b1;

  function automatic int frame_len(input int reg_bytes);
    return 1 + reg_bytes;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream word interface between the sequencer and the SPI master.
interface axis_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/spi_reg_access_ctrl.sv
// Serialises one register read/write command into an AXIS frame for the SPI
// master and collects the returned MISO words into a single response.
module spi_reg_access_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int REG_BYTES  = 2,
  parameter int SLAVE_NUM  = 2,
  parameter int TIMEOUT    = 4096,
  localparam int SW        = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
  localparam int RW        = REG_BYTES * DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_rw_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [RW-1:0]         cmd_wdata_i,
  input  logic [SW-1:0]         cmd_slave_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [RW-1:0]         rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [SW-1:0]         spi_addr_o,
  axis_if.master                m_axis,
  axis_if.slave                 s_axis
);

  localparam int FLEN = frame_len(REG_BYTES);
  localparam int CW   = $clog2(FLEN + 1);
  localparam int TW   = $clog2(TIMEOUT);

  reg_acc_state_t        state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RW-1:0]         wdata_q, wdata_d;
  logic [SW-1:0]         spi_addr_q, spi_addr_d;
  logic [CW-1:0]         tx_idx_q, tx_idx_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [RW-1:0]         rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  eof_q, eof_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;

  logic [DATA_WIDTH-1:0] tx_word;
  logic                  rx_done;
  logic                  rx_fire;
  logic                  in_frame;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      spi_addr_q <= '0;
      tx_idx_q   <= '0;
      rx_cnt_q   <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      eof_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      spi_addr_q <= spi_addr_d;
      tx_idx_q   <= tx_idx_d;
      rx_cnt_q   <= rx_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      eof_q      <= eof_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Outgoing word is a pure function of registered state, so it holds under back-pressure.
  always_comb begin
    tx_word = '0;
    if (tx_idx_q == '0) begin
      tx_word = {rw_q, addr_q};
    end else if (rw_q != RW_READ) begin
      for (int k = 1; k <= REG_BYTES; k++) begin
        if (tx_idx_q == CW'(k)) tx_word = wdata_q[(REG_BYTES-k)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_frame = (state_q == SEND) || (state_q == DRAIN);
  assign rx_done  = (rx_cnt_q == CW'(FLEN)) || eof_q;
  assign rx_fire  = s_axis.tvalid && in_frame && !rx_done;

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    spi_addr_d = spi_addr_q;
    tx_idx_d   = tx_idx_q;
    rx_cnt_d   = rx_cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    eof_d      = eof_q;
    to_cnt_d   = to_cnt_q;

    if (rx_fire) begin
      rx_cnt_d = rx_cnt_q + 1'b1;
      if (rx_cnt_q != '0) rdata_d = (rdata_q << DATA_WIDTH) | RW'(s_axis.tdata);
      if (s_axis.tlast != (rx_cnt_q == CW'(FLEN - 1))) err_d = 1'b1;
      if (s_axis.tlast) eof_d = 1'b1;
    end

    // Idle-gap watchdog: cleared by every received word, saturates at its limit.
    if (in_frame) begin
      if (rx_fire) to_cnt_d = '0;
      else if (to_cnt_q != TW'(TIMEOUT - 1)) to_cnt_d = to_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          rw_d       = cmd_rw_i;
          addr_d     = cmd_addr_i;
          wdata_d    = cmd_wdata_i;
          spi_addr_d = cmd_slave_i;
          tx_idx_d   = '0;
          rx_cnt_d   = '0;
          rdata_d    = '0;
          err_d      = 1'b0;
          eof_d      = 1'b0;
          to_cnt_d   = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (m_axis.tready) begin
          tx_idx_d = tx_idx_q + 1'b1;
          if (tx_idx_q == CW'(FLEN - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (rx_done) begin
          state_d = RESP;
        end else if (!rx_fire && to_cnt_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = (rw_q == RW_READ) ? rdata_q : '0;
  assign rsp_err_o     = err_q;
  assign spi_addr_o    = spi_addr_q;

  assign m_axis.tvalid = (state_q == SEND);
  assign m_axis.tdata  = tx_word;
  assign m_axis.tlast  = (state_q == SEND) && (tx_idx_q == CW'(FLEN - 1));
  assign s_axis.tready = 1'b1;

endmodule

// File: tb/tb_spi_reg_access_ctrl.sv
// Directed + randomized bench for spi_reg_access_ctrl with a frame-level reference model.
module tb_spi_reg_access_ctrl;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int RB = 2;
  localparam int SN = 2;
  localparam int TO = 256;
  localparam int FL = RB + 1;

  logic              clk_i;
  logic              arst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_rw_i;
  logic [AW-1:0]     cmd_addr_i;
  logic [RB*DW-1:0]  cmd_wdata_i;
  logic              cmd_slave_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [RB*DW-1:0]  rsp_rdata_o;
  logic              rsp_err_o;
  logic              spi_addr_o;

  axis_if #(.DATA_WIDTH(DW)) m_if ();
  axis_if #(.DATA_WIDTH(DW)) s_if ();

  int checks;
  int errors;

  spi_reg_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_BYTES(RB), .SLAVE_NUM(SN), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rw_i(cmd_rw_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_slave_i(cmd_slave_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .spi_addr_o(spi_addr_o),
    .m_axis(m_if), .s_axis(s_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One full command: drive it, play the SPI slave, then compare against the frame model.
  task automatic run_txn(input logic rw, input logic [AW-1:0] addr, input logic [15:0] wdata,
                         input logic sl, input logic [23:0] miso, input logic [2:0] lastm,
                         input int n_deliver, input int stall_word, input bit rnd_ready,
                         input int max_dly, input string tag);
    logic [7:0]  tx_got[$];
    logic        tl_got[$];
    int          rx_due[$];
    int          k, last_rx_k, rsp_k, stall_left, rx_sent, next_due, dly, hold;
    logic        prev_stall, prev_last, r;
    logic [7:0]  prev_data, exp_word;
    bit          got, any_last, exp_err, exp_to, addr_bad, hold_bad, tready_bad;
    logic [15:0] exp_rdata;

    exp_rdata = '0;
    exp_err   = 1'b0;
    any_last  = 1'b0;
    for (int i = 0; i < n_deliver; i++) begin
      if (lastm[i] != (i == FL - 1)) exp_err = 1'b1;
      if (lastm[i]) any_last = 1'b1;
      if (i >= 1) exp_rdata = (exp_rdata << 8) | 16'((miso >> (8 * (2 - i))) & 24'hFF);
    end
    exp_to = (n_deliver < FL) && !any_last;
    if (exp_to) exp_err = 1'b1;
    if (!rw) exp_rdata = '0;

    @(negedge clk_i);
    chk({tag, " cmd_ready idle"}, 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    cmd_rw_i    = rw;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_slave_i = sl;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk({tag, " cmd_ready busy"}, 64'(cmd_ready_o), 64'd0);

    k = 0; got = 0; rsp_k = -1; last_rx_k = -1; stall_left = -1; rx_sent = 0; next_due = 0;
    prev_stall = 0; prev_data = '0; prev_last = 0;
    addr_bad = 0; hold_bad = 0; tready_bad = 0;
    while (!got && k < TO + 100) begin
      if (spi_addr_o !== sl) addr_bad = 1;
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== prev_data || m_if.tlast !== prev_last))
        hold_bad = 1;
      if (rsp_valid_o) begin
        got = 1;
        rsp_k = k;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
      end else begin
        r = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (m_if.tvalid && tx_got.size() == stall_word) begin
          if (stall_left < 0) stall_left = 5;
          if (stall_left > 0) begin
            r = 1'b0;
            stall_left--;
          end
        end
        m_if.tready = r;
        prev_stall  = m_if.tvalid && !r;
        prev_data   = m_if.tdata;
        prev_last   = m_if.tlast;
        if (m_if.tvalid && r) begin
          if (tx_got.size() < n_deliver) begin
            dly = k + $urandom_range(0, max_dly);
            if (dly > next_due) next_due = dly;
            rx_due.push_back(next_due);
          end
          tx_got.push_back(m_if.tdata);
          tl_got.push_back(m_if.tlast);
        end
        if (rx_due.size() > 0 && rx_due[0] <= k) begin
          void'(rx_due.pop_front());
          s_if.tvalid = 1'b1;
          s_if.tdata  = 8'((miso >> (8 * (2 - rx_sent))) & 24'hFF);
          s_if.tlast  = lastm[rx_sent];
          rx_sent++;
          last_rx_k = k;
        end else begin
          s_if.tvalid = 1'b0;
          s_if.tdata  = 8'($urandom);
          s_if.tlast  = 1'($urandom);
        end
        if (s_if.tready !== 1'b1) tready_bad = 1;
        @(negedge clk_i);
        k++;
      end
    end
    rx_due.delete();

    chk({tag, " rsp seen"}, 64'(got), 64'd1);
    chk({tag, " tx count"}, 64'(tx_got.size()), 64'(FL));
    for (int i = 0; i < tx_got.size() && i < FL; i++) begin
      if (i == 0) exp_word = {rw, addr};
      else if (rw) exp_word = 8'h00;
      else exp_word = 8'((wdata >> (8 * (RB - i))) & 16'hFF);
      chk($sformatf("%s tx word %0d", tag, i), 64'(tx_got[i]), 64'(exp_word));
      chk($sformatf("%s tx last %0d", tag, i), 64'(tl_got[i]), 64'(i == FL - 1));
    end
    chk({tag, " err"}, 64'(rsp_err_o), 64'(exp_err));
    chk({tag, " rdata"}, 64'(rsp_rdata_o), 64'(exp_rdata));
    if (exp_to) chk({tag, " timeout latency"}, 64'(rsp_k - last_rx_k), 64'(TO + 1));
    chk({tag, " spi_addr held"}, 64'(addr_bad), 64'd0);
    chk({tag, " tx held on stall"}, 64'(hold_bad), 64'd0);
    chk({tag, " s_tready high"}, 64'(tready_bad), 64'd0);

    hold = $urandom_range(0, 2);
    for (int j = 0; j < hold; j++) begin
      @(negedge clk_i);
      chk({tag, " rsp held"}, 64'(rsp_valid_o), 64'd1);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk({tag, " rsp dropped"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, " ready after rsp"}, 64'(cmd_ready_o), 64'd1);
    $display("txn %s rw=%0d addr=%h wdata=%h slave=%0d err=%0d/%0d rdata=%h/%h",
             tag, rw, addr, wdata, sl, exp_err, rsp_err_o, exp_rdata, rsp_rdata_o);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_rw_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0; cmd_slave_i = 1'b0;
    rsp_ready_i = 1'b0;
    m_if.tready = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;

    repeat (2) @(negedge clk_i);
    chk("reset tvalid", 64'(m_if.tvalid), 64'd0);
    chk("reset rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset spi_addr", 64'(spi_addr_o), 64'd0);
    arst_i = 1'b0;
    @(negedge clk_i);
    chk("reset cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("reset s_tready", 64'(s_if.tready), 64'd1);

    run_txn(1'b0, 7'h15, 16'hBEEF, 1'b1, 24'h11_22_33, 3'b100, 3, -1, 1'b0, 0, "write_beef");
    run_txn(1'b1, 7'h03, 16'h0000, 1'b0, 24'hA5_12_34, 3'b100, 3, -1, 1'b0, 2, "read_03");
    run_txn(1'b0, 7'h2A, 16'hC3_5A, 1'b1, 24'h00_00_00, 3'b100, 3, 1, 1'b0, 1, "stall_mid");
    run_txn(1'b1, 7'h44, 16'h0000, 1'b1, 24'h77_88_99, 3'b000, 1, -1, 1'b0, 0, "timeout");
    run_txn(1'b1, 7'h10, 16'h0000, 1'b0, 24'hDE_AD_BE, 3'b001, 1, -1, 1'b0, 0, "early_tlast");
    run_txn(1'b1, 7'h11, 16'h0000, 1'b0, 24'h01_9C_E7, 3'b000, 3, -1, 1'b0, 1, "no_tlast");

    // Stray word while idle must be ignored.
    @(negedge clk_i);
    s_if.tvalid = 1'b1; s_if.tdata = 8'h5A; s_if.tlast = 1'b1;
    @(negedge clk_i);
    s_if.tvalid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("stray rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("stray cmd_ready", 64'(cmd_ready_o), 64'd1);
      @(negedge clk_i);
    end
    run_txn(1'b1, 7'h7F, 16'h0000, 1'b1, 24'h3C_AB_CD, 3'b100, 3, -1, 1'b1, 2, "after_stray");

    // Reset while a frame is stalled in flight.
    @(negedge clk_i);
    m_if.tready = 1'b0;
    cmd_valid_i = 1'b1; cmd_rw_i = 1'b0; cmd_addr_i = 7'h21; cmd_wdata_i = 16'h1357; cmd_slave_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("pre-reset tvalid", 64'(m_if.tvalid), 64'd1);
    chk("pre-reset spi_addr", 64'(spi_addr_o), 64'd1);
    arst_i = 1'b1;
    #1;
    chk("arst tvalid", 64'(m_if.tvalid), 64'd0);
    chk("arst cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("arst rsp_valid", 64'(rsp_valid_o), 64'd0);
    @(negedge clk_i);
    arst_i = 1'b0;
    @(negedge clk_i);
    chk("post-reset cmd_ready", 64'(cmd_ready_o), 64'd1);
    chk("post-reset rsp_valid", 64'(rsp_valid_o), 64'd0);
    run_txn(1'b0, 7'h21, 16'h1357, 1'b1, 24'h00_00_00, 3'b100, 3, -1, 1'b0, 0, "after_reset");

    for (int n = 0; n < 8; n++) begin
      run_txn(1'($urandom), 7'($urandom), 16'($urandom), 1'($urandom), 24'($urandom),
              3'b100, 3, -1, 1'b1, 3, $sformatf("rand_%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
